// File: rtl/pulse_stretch.sv
// pulse_stretch: stretch each trig rising edge into an LED blink of minimum on-time and off-gap, queuing events that arrive mid-blink.
module pulse_stretch #(
  parameter int N = 19,
  parameter int ON_TICKS = 20,
  parameter int OFF_TICKS = 10,
  parameter int PEND_MAX = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       trig,
  output logic       led,
  output logic       busy,
  output logic [3:0] pend,
  output logic       drop
);
  typedef enum logic [1:0] {IDLE, ON, OFF} state_t;
  state_t state;
  logic [N-1:0] q_reg;
  logic [7:0] tcnt;
  logic trig_d, m_tick, ev, on_done, off_done, consume, direct, queue, full;
  assign m_tick = &q_reg;
  assign ev = trig & ~trig_d;
  assign on_done = (state == ON) && m_tick && (tcnt == 8'(ON_TICKS - 1));
  assign off_done = (state == OFF) && m_tick && (tcnt == 8'(OFF_TICKS - 1));
  assign consume = off_done && (pend != 4'd0);
  // an event landing on an empty-queue OFF exit starts the next blink directly
  assign direct = off_done && (pend == 4'd0) && ev;
  assign queue = ev && (state != IDLE) && !direct;
  assign full = pend == 4'(PEND_MAX);
  assign drop = queue && !consume && full;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      q_reg <= '0;
      tcnt <= '0;
      trig_d <= 1'b0;
      pend <= '0;
      led <= 1'b0;
      busy <= 1'b0;
    end else begin
      q_reg <= q_reg + 1'b1;
      trig_d <= trig;
      pend <= consume ? pend - {3'd0, !queue} : pend + {3'd0, queue && !full};
      case (state)
        IDLE: if (ev) begin
          state <= ON;
          led <= 1'b1;
          busy <= 1'b1;
          tcnt <= '0;
        end
        ON: if (on_done) begin
          state <= OFF;
          led <= 1'b0;
          tcnt <= '0;
        end else if (m_tick) tcnt <= tcnt + 1'b1;
        OFF: if (off_done) begin
          state <= (consume || ev) ? ON : IDLE;
          led <= consume || ev;
          busy <= consume || ev;
          tcnt <= '0;
        end else if (m_tick) tcnt <= tcnt + 1'b1;
        default: begin
          state <= IDLE;
          led <= 1'b0;
          busy <= 1'b0;
          tcnt <= '0;
        end
      endcase
    end
endmodule

// File: doc/pulse_stretch.md
Name: pulse_stretch

Overview:
- Output-side counterpart to the button input conditioner: the conditioner rejects pulses that are too short; this block extends short events into visible indicator pulses.
- Turns each rising edge on a synchronous event input (debounced key, 1-cycle strobe) into an LED pulse of guaranteed minimum on-time, followed by a guaranteed minimum off-gap.
- Events arriving during a pulse are queued, so each one produces its own distinct blink.
- Sits between the debounced/processed event logic and the board LEDs.

Parameters:
- N, 19: prescaler width; tick period is 2^N clk cycles (2^19 × 20 ns ≈ 10 ms).
- ON_TICKS, 20: minimum LED on-time in ticks; range 1..255.
- OFF_TICKS, 10: minimum LED off-gap in ticks after each pulse; range 1..255.
- PEND_MAX, 15: saturation limit of the pending-event counter; range 1..15.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- trig  input  1  event input, already synchronous to clk; each rising edge is one event
- led  output  1  stretched pulse output to the LED
- busy  output  1  high while the FSM is not IDLE
- pend  output  4  number of queued events not yet shown
- drop  output  1  one-cycle strobe: event lost because pend was at PEND_MAX

Behaviour:
- Reset (async, active-high) sets all registers to 0 and state to IDLE. Outputs during and after reset: led=0, busy=0, pend=0, drop=0.
- trig_d also resets to 0, so trig held high through reset release counts as one event.
- Prescaler: N-bit q_reg, cleared by reset, increments every clk. m_tick=1 when q_reg is all ones.
- Edge detect: trig_d <= trig; ev = trig & ~trig_d (combinational).
- Tick counter tcnt (8 bits):
  - cleared on every state change;
  - increments on m_tick while in ON or OFF.
- FSM, three states; led=1 only in ON; busy = (state != IDLE).
  - IDLE: on ev → ON. led rises on the clk edge that samples ev (1-cycle latency from trig rising).
  - ON: when m_tick and tcnt==ON_TICKS-1 → OFF.
    - On-time is between (ON_TICKS-1)·2^N+1 and ON_TICKS·2^N cycles, because the first tick is partial.
  - OFF: when m_tick and tcnt==OFF_TICKS-1, the exit is decided as follows:
    - pend>0 → ON, pend decrements;
    - else ev in the same cycle → ON, pend unchanged;
    - else → IDLE.
- Pending counter:
  - ev in ON or OFF: pend+1, saturating at PEND_MAX.
  - ev with pend==PEND_MAX: pend holds and drop=1 for that cycle.
  - ev in the same cycle as the OFF→ON decrement: net pend unchanged; counts as queued-then-consumed, drop=0.
  - ev in IDLE never touches pend.
- An event is never shortened or merged: every accepted event yields exactly one ON period.
- Reset mid-pulse: led drops immediately (async), queue is discarded, tcnt and prescaler restart from 0.
- Default branch of the state case forces IDLE.
- drop is registered-free combinational from ev, pend and state, and is valid only while clk is running.

Test Plan (bench uses N=3, i.e. tick = 8 cycles; ON_TICKS=2; OFF_TICKS=1; PEND_MAX=3):
- Reset released, trig low: led=0, busy=0, pend=0, drop=0; led stays 0 for 100 cycles.
- 1-cycle trig pulse at cycle 20: led=1 from cycle 21 for 9..16 cycles (ON_TICKS=2, partial first tick), then led=0 for 1..8 cycles, then busy=0 and pend=0.
- Three 1-cycle pulses spaced 2 cycles apart: first pulse gives led=1 and pend reaches 2; exactly three separate led high periods, each ≥9 cycles, separated by low gaps ≥1 cycle; pend counts 2→1→0; busy falls after the third gap.
- Six pulses, 2 cycles apart, all inside the first ON period: pend saturates at 3; drop pulses once each for the 5th and 6th events; exactly 4 blinks total.
- trig held high 200 cycles: exactly one blink; no further events; pend=0.
- Event coincident with the OFF-exit cycle, pend=0: the FSM goes ON directly with no IDLE cycle and pend stays 0.
- Reset asserted asynchronously mid-ON with pend=2: led, busy and pend go to 0 without a clk edge; after release with trig low, no blinks occur.
- trig high while reset releases: one blink.
